uart_tx_arbiter: RTL and testbench

- Shares the single SoC UART transmit byte stream between NumReq requesters, e.g. the core's TX path and the debug/console path.
- Grants are packet-atomic: once granted, a requester owns the UART until its last byte is accepted.
- Ownership then rotates round-robin.
- Sits between the requester byte streams and the UART TX serializer; the output is a registered valid/ready byte stream.

---
 rtl/uart_arb_pkg.sv | 9 +
 rtl/uart_arb_rr_pick.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX byte-stream arbiter.
package uart_arb_pkg;

    typedef enum logic {IDLE, LOCK} arb_state_e;

    localparam int unsigned MaxNumReq        = 8;
    localparam int unsigned DefTimeoutCycles = 1024;

endpackage

// File: rtl/uart_arb_rr_pick.sv
// Combinational round-robin finder: first set request bit at or after rr_ptr, wrapping.
module uart_arb_rr_pick #(
    parameter  int unsigned NumReq = 2,
    localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   rr_ptr,
    output logic [IdxW-1:0]   winner,
    output logic              any_valid
);

    int unsigned idx;

    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            idx = (32'(rr_ptr) + k) % NumReq;
            if (!any_valid && req[idx]) begin
                winner    = IdxW'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART TX byte stream among NumReq requesters.
// Optional idle-owner lock timeout is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int unsigned NumReq        = 2,
    parameter  int unsigned TimeoutCycles = DefTimeoutCycles,
    localparam int unsigned IdxW          = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumReq-1:0]      req_valid_i,
    input  logic [NumReq-1:0][7:0] req_data_i,
    input  logic [NumReq-1:0]      req_last_i,
    output logic [NumReq-1:0]      req_ready_o,
    output logic                   tx_valid_o,
    output logic [7:0]             tx_data_o,
    input  logic                   tx_ready_i,
    output logic [IdxW-1:0]        owner_o,
    output logic                   busy_o,
    output logic                   timeout_o
);

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] rr_q, rr_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [IdxW-1:0] winner;
    logic [IdxW-1:0] next_ptr;
    logic            any_valid;
    logic            owner_valid;
    logic            owner_last;
    logic            out_free;
    logic            accept;
    logic            timeout_d;
    logic            tx_valid_q;
    logic [7:0]      tx_data_q;

    uart_arb_rr_pick #(
        .NumReq(NumReq)
    ) u_pick (
        .req      (req_valid_i),
        .rr_ptr   (rr_q),
        .winner   (winner),
        .any_valid(any_valid)
    );

    assign owner_valid = req_valid_i[owner_q];
    assign owner_last  = req_last_i[owner_q];
    assign out_free    = !tx_valid_q || tx_ready_i;
    assign accept      = (state_q == LOCK) && owner_valid && out_free;
    assign next_ptr    = (owner_q == IdxW'(NumReq - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        req_ready_o = '0;
        if (state_q == LOCK && out_free) begin
            req_ready_o[owner_q] = 1'b1;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    logic [CntW-1:0] stall_cnt_q;
    logic            timeout_q;
    logic            stall_expired;

    assign stall_expired = !owner_valid && (stall_cnt_q == CntW'(TimeoutCycles - 1));

    // Counter only advances while the owner holds the lock without presenting data.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
            if (state_q != LOCK || accept) begin
                stall_cnt_q <= '0;
            end else if (!owner_valid) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    owner_d = winner;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (accept && owner_last) begin
                    state_d = IDLE;
                    rr_d    = next_ptr;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (stall_expired) begin
                    state_d   = IDLE;
                    rr_d      = next_ptr;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
        end
    end

    // A new beat takes priority over draining, keeping one byte per cycle under tx_ready_i.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else if (accept) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= req_data_i[owner_q];
        end else if (tx_ready_i) begin
            tx_valid_q <= 1'b0;
        end
    end

    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_data_q;
    assign owner_o    = owner_q;
    assign busy_o     = (state_q == LOCK);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with three requesters and hand-computed byte orders.
module tb_uart_tx_arbiter;

    localparam int unsigned N = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       req_valid;
    logic [N-1:0][7:0]  req_data;
    logic [N-1:0]       req_last;
    logic [N-1:0]       req_ready;
    logic               tx_valid;
    logic [7:0]         tx_data;
    logic               tx_ready;
    logic [1:0]         owner;
    logic               busy;
    logic               timeout;

    int total = 0;
    int bad   = 0;

    logic [7:0]  q_data [N][16];
    logic        q_last [N][16];
    int unsigned q_n    [N];
    int unsigned q_pos  [N];
    logic [7:0]  tx_log [$];
    int unsigned own_log[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NumReq(N),
        .TimeoutCycles(16)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_valid_i(req_valid),
        .req_data_i (req_data),
        .req_last_i (req_last),
        .req_ready_o(req_ready),
        .tx_valid_o (tx_valid),
        .tx_data_o  (tx_data),
        .tx_ready_i (tx_ready),
        .owner_o    (owner),
        .busy_o     (busy),
        .timeout_o  (timeout)
    );

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (q_pos[i] < q_n[i]) begin
                req_valid[i] = 1'b1;
                req_data[i]  = q_data[i][q_pos[i]];
                req_last[i]  = q_last[i][q_pos[i]];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i]  = '0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic load(input int r, input logic [7:0] d, input logic l);
        q_data[r][q_n[r]] = d;
        q_last[r][q_n[r]] = l;
        q_n[r]++;
    endtask

    task automatic clear_q();
        for (int i = 0; i < N; i++) begin
            q_n[i]   = 0;
            q_pos[i] = 0;
        end
        tx_log.delete();
        own_log.delete();
    endtask

    // Handshakes are sampled at the negedge, queues advance just after the posedge.
    task automatic cycle();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = rst_n ? (req_valid & req_ready) : '0;
        if (rst_n && tx_valid && tx_ready) tx_log.push_back(tx_data);
        if (acc != '0) own_log.push_back(32'(owner));
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (acc[i]) q_pos[i]++;
        drive();
        #1;
    endtask

    function automatic bit all_done();
        for (int i = 0; i < N; i++) if (q_pos[i] < q_n[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_idle(input string name);
        int unsigned k = 0;
        while (!(all_done() && !tx_valid && !busy) && k < 200) begin
            cycle();
            k++;
        end
        total++;
        if (k >= 200) begin
            bad++;
            $display("FAIL %s_drain: still busy after %0d cycles, want idle", name, k);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        tx_ready = 1'b1;
        clear_q();
        drive();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL rst_ready: got %b want 000", req_ready); end
        total++; if (owner !== 2'd0) begin bad++; $display("FAIL rst_owner: got %0d want 0", owner); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b want 0", timeout); end
    endtask

    task automatic test_reset_mid_packet();
        logic [7:0] exp_b[$];
        do_reset();
        load(0, 8'h11, 1'b0); load(0, 8'h22, 1'b0); load(0, 8'h33, 1'b1);
        drive();
        cycle(); cycle(); cycle();
        total++; if (tx_data !== 8'h22) begin bad++; $display("FAIL midrst_pre: got %h want 22", tx_data); end
        rst_n    = 1'b0;
        q_n[0]   = q_pos[0];
        drive();
        cycle();
        rst_n = 1'b1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL midrst_tx_valid: got %b want 0", tx_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        total++; if (owner !== 2'd0) begin bad++; $display("FAIL midrst_owner: got %0d want 0", owner); end
        load(1, 8'h44, 1'b1);
        drive();
        cycle();
        total++; if (owner !== 2'd1) begin bad++; $display("FAIL midrst_grant: got %0d want 1", owner); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_grant_busy: got %b want 1", busy); end
        run_idle("midrst");
        exp_b = '{8'h11, 8'h44};
        total++; if (tx_log.size() != exp_b.size()) begin bad++; $display("FAIL midrst_len: got %0d want %0d", tx_log.size(), exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < tx_log.size(); i++) begin
            total++; if (tx_log[i] !== exp_b[i]) begin bad++; $display("FAIL midrst_byte%0d: got %h want %h", i, tx_log[i], exp_b[i]); end
        end
    endtask

    task automatic test_single();
        logic [7:0] exp_b[$];
        do_reset();
        load(0, 8'hA5, 1'b0); load(0, 8'h5A, 1'b1);
        drive();
        #1;
        total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL single_t0_ready: got %b want 000", req_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_t0_busy: got %b want 0", busy); end
        cycle();
        total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL single_t1_ready: got %b want 001", req_ready); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_t1_busy: got %b want 1", busy); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL single_t1_valid: got %b want 0", tx_valid); end
        cycle();
        total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL single_t2_valid: got %b want 1", tx_valid); end
        total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL single_t2_data: got %h want a5", tx_data); end
        cycle();
        total++; if (tx_data !== 8'h5A) begin bad++; $display("FAIL single_t3_data: got %h want 5a", tx_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_t3_busy: got %b want 0", busy); end
        total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL single_t3_ready: got %b want 000", req_ready); end
        load(0, 8'h77, 1'b1);
        load(2, 8'h88, 1'b1);
        drive();
        cycle();
        total++; if (owner !== 2'd2) begin bad++; $display("FAIL single_rrptr_owner: got %0d want 2", owner); end
        run_idle("single");
        exp_b = '{8'hA5, 8'h5A, 8'h88, 8'h77};
        total++; if (tx_log.size() != exp_b.size()) begin bad++; $display("FAIL single_len: got %0d want %0d", tx_log.size(), exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < tx_log.size(); i++) begin
            total++; if (tx_log[i] !== exp_b[i]) begin bad++; $display("FAIL single_byte%0d: got %h want %h", i, tx_log[i], exp_b[i]); end
        end
    endtask

    task automatic test_contention();
        logic [7:0]  exp_b[$];
        int unsigned exp_o[$];
        do_reset();
        load(0, 8'h01, 1'b0); load(0, 8'h02, 1'b1); load(0, 8'h05, 1'b0); load(0, 8'h06, 1'b1);
        load(1, 8'h03, 1'b0); load(1, 8'h04, 1'b1);
        drive();
        run_idle("contention");
        exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        exp_o = '{0, 0, 1, 1, 0, 0};
        total++; if (tx_log.size() != exp_b.size()) begin bad++; $display("FAIL cont_len: got %0d want %0d", tx_log.size(), exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < tx_log.size(); i++) begin
            total++; if (tx_log[i] !== exp_b[i]) begin bad++; $display("FAIL cont_byte%0d: got %h want %h", i, tx_log[i], exp_b[i]); end
        end
        total++; if (own_log.size() != exp_o.size()) begin bad++; $display("FAIL cont_beats: got %0d want %0d", own_log.size(), exp_o.size()); end
        for (int i = 0; i < exp_o.size() && i < own_log.size(); i++) begin
            total++; if (own_log[i] != exp_o[i]) begin bad++; $display("FAIL cont_owner%0d: got %0d want %0d", i, own_log[i], exp_o[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_b[$];
        do_reset();
        load(0, 8'hB0, 1'b0); load(0, 8'hB1, 1'b0); load(0, 8'hB2, 1'b0); load(0, 8'hB3, 1'b1);
        drive();
        cycle(); cycle(); cycle();
        total++; if (tx_data !== 8'hB1) begin bad++; $display("FAIL bp_pre_data: got %h want b1", tx_data); end
        tx_ready = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL bp_ready_c%0d: got %b want 000", c, req_ready); end
            total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_c%0d: got %b want 1", c, tx_valid); end
            total++; if (tx_data !== 8'hB1) begin bad++; $display("FAIL bp_data_c%0d: got %h want b1", c, tx_data); end
            cycle();
        end
        tx_ready = 1'b1;
        run_idle("bp");
        exp_b = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        total++; if (tx_log.size() != exp_b.size()) begin bad++; $display("FAIL bp_len: got %0d want %0d", tx_log.size(), exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < tx_log.size(); i++) begin
            total++; if (tx_log[i] !== exp_b[i]) begin bad++; $display("FAIL bp_byte%0d: got %h want %h", i, tx_log[i], exp_b[i]); end
        end
    endtask

    task automatic test_wrap();
        logic [7:0]  exp_b[$];
        int unsigned exp_o[$];
        do_reset();
        load(0, 8'h10, 1'b1); load(0, 8'h13, 1'b1);
        load(1, 8'h11, 1'b1); load(1, 8'h14, 1'b1);
        load(2, 8'h12, 1'b1); load(2, 8'h15, 1'b1);
        drive();
        run_idle("wrap");
        exp_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        exp_o = '{0, 1, 2, 0, 1, 2};
        total++; if (tx_log.size() != exp_b.size()) begin bad++; $display("FAIL wrap_len: got %0d want %0d", tx_log.size(), exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < tx_log.size(); i++) begin
            total++; if (tx_log[i] !== exp_b[i]) begin bad++; $display("FAIL wrap_byte%0d: got %h want %h", i, tx_log[i], exp_b[i]); end
        end
        total++; if (own_log.size() != exp_o.size()) begin bad++; $display("FAIL wrap_grants: got %0d want %0d", own_log.size(), exp_o.size()); end
        for (int i = 0; i < exp_o.size() && i < own_log.size(); i++) begin
            total++; if (own_log[i] != exp_o[i]) begin bad++; $display("FAIL wrap_owner%0d: got %0d want %0d", i, own_log[i], exp_o[i]); end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        tx_ready = 1'b1;
        clear_q();
        drive();
        test_reset();
        test_reset_mid_packet();
        test_single();
        test_contention();
        test_backpressure();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
